// File: rtl/scr1_tcm_loader_pkg.sv
// Shared definitions for the TCM boot loader: FSM state encoding and the
// fixed byte counts of the load stream framing.
package scr1_tcm_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LEN0  = 3'd1;
  localparam state_t ST_LEN1  = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_WRITE = 3'd4;
  localparam state_t ST_CHECK = 3'd5;
  localparam state_t ST_DONE  = 3'd6;
  localparam state_t ST_ERR   = 3'd7;

  localparam int HDR_BYTES  = 2;
  localparam int CHK_BYTES  = 1;
  localparam int WORD_BYTES = 4;

  // States in which the loader accepts a byte from the stream.
  function automatic logic accepts_byte(state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/scr1_tcm_loader_asm.sv
// Little-endian byte-to-word assembler with a running XOR over every data
// byte it absorbs.
module scr1_tcm_loader_asm
  import scr1_tcm_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word_next,
  output logic [7:0]  chk,
  output logic        last
);

  logic [31:0] word;
  logic [1:0]  byte_idx;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    word_next = word;
    word_next[8*byte_idx +: 8] = data;
  end

  assign last = take && (byte_idx == 2'(WORD_BYTES - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word     <= '0;
      byte_idx <= '0;
      chk      <= '0;
    end else if (clr) begin
      word     <= '0;
      byte_idx <= '0;
      chk      <= '0;
    end else if (take) begin
      word     <= word_next;
      byte_idx <= byte_idx + 2'd1;
      chk      <= chk ^ data;
    end
  end

endmodule

// File: rtl/scr1_tcm_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked byte stream and writes
// it into TCM port B while holding the core in reset.
module scr1_tcm_loader
  import scr1_tcm_loader_pkg::*;
#(
  parameter  int SCR1_WIDTH = 32,
  parameter  int SCR1_SIZE  = 32'h00010000,
  localparam int AW         = $clog2(SCR1_SIZE) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wenb,
  output logic [3:0]            mem_webb,
  output logic [AW-1:0]         mem_addrb,
  output logic [SCR1_WIDTH-1:0] mem_datab,
  output logic                  core_rst_n,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0] MAX_WORDS = 32'(SCR1_SIZE / 4);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [AW:0] word_idx;
  logic        fire;
  logic        restart;
  logic        asm_last;
  logic [31:0] asm_word;
  logic [7:0]  asm_chk;

  assign in_ready = accepts_byte(state);
  assign fire     = in_valid && in_ready;
  assign restart  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign len_full = {in_data, len_lo};

  // Write strobes come straight from the state so the 4th byte reaches the
  // memory one cycle after it is accepted.
  assign mem_wenb = (state == ST_WRITE);
  assign mem_webb = {4{mem_wenb}};

  scr1_tcm_loader_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (restart),
    .take      (fire && (state == ST_DATA)),
    .data      (in_data),
    .word_next (asm_word),
    .chk       (asm_chk),
    .last      (asm_last)
  );

  // NOTE: there is no storage array here, so every register has a reset
  // value; the TCM itself is deliberately never cleared by this block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      mem_addrb  <= '0;
      mem_datab  <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (restart) begin
            state      <= ST_LEN0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_idx   <= '0;
            core_rst_n <= 1'b0;
          end
        end
        ST_LEN0: begin
          if (fire) begin
            len_lo <= in_data;
            state  <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (fire) begin
            len <= len_full;
            if ({16'd0, len_full} > MAX_WORDS) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // Capture address and word together so they stay stable afterwards.
          if (asm_last) begin
            state     <= ST_WRITE;
            mem_addrb <= word_idx[AW-1:0];
            mem_datab <= asm_word;
          end
        end
        ST_WRITE: begin
          word_idx <= word_idx + 1'b1;
          if (32'(word_idx) + 32'd1 == 32'(len)) state <= ST_CHECK;
          else                                    state <= ST_DATA;
        end
        ST_CHECK: begin
          if (fire) begin
            if (in_data == asm_chk) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_tcm_loader.sv
// Randomised self-checking bench for scr1_tcm_loader against a stream-level
// model: expected words, checksum and status are derived from the byte format.
module tb_scr1_tcm_loader;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_wenb;
  logic [3:0]    mem_webb;
  logic [AW-1:0] mem_addrb;
  logic [31:0]   mem_datab;
  logic          core_rst_n;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int webb_bad = 0;

  logic [31:0]   exp_words[$];
  logic [7:0]    stream[$];
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];

  scr1_tcm_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_wenb   (mem_wenb),
    .mem_webb   (mem_webb),
    .mem_addrb  (mem_addrb),
    .mem_datab  (mem_datab),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Log every write-port strobe and any illegal byte-enable pattern.
  always @(negedge clk) begin
    if (mem_wenb) begin
      wr_addr.push_back(mem_addrb);
      wr_data.push_back(mem_datab);
      if (mem_webb != 4'hF) webb_bad++;
    end else if (mem_webb != 4'h0) begin
      webb_bad++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serialise exp_words into the load format; good says whether CHK matches.
  task automatic build_stream(input int len, input int chk_force, output bit good);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    stream.delete();
    stream.push_back(len[7:0]);
    stream.push_back(len[15:8]);
    foreach (exp_words[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = exp_words[i][8*k +: 8];
        stream.push_back(b);
        x ^= b;
      end
    end
    if (chk_force < 0) begin
      stream.push_back(x);
      good = 1'b1;
    end else begin
      stream.push_back(chk_force[7:0]);
      good = (chk_force[7:0] == x);
    end
  endtask

  task automatic send_stream(input int first, input int stop, input bit hold, output int cycles);
    int idx;
    bit fire;
    idx = first;
    cycles = 0;
    while (idx < stop && cycles < 4000) begin
      @(negedge clk);
      in_valid = hold || ($urandom_range(3) != 0);
      in_data  = stream[idx];
      fire     = in_valid && in_ready;
      @(posedge clk);
      if (fire) idx++;
      cycles++;
    end
    #1 in_valid = 1'b0;
    if (idx < stop) check("stream_timeout", 64'(idx), 64'(stop));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Full load of exp_words; split > 0 pulses a (to be ignored) start mid-stream.
  task automatic run_load(input string tag, input int chk_force, input bit hold, input int split);
    bit good;
    int cyc;
    int cyc2;
    int n;
    n = exp_words.size();
    build_stream(n, chk_force, good);
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    if (split > 0) begin
      send_stream(0, split, hold, cyc);
      pulse_start();
      send_stream(split, stream.size(), hold, cyc2);
      cyc += cyc2;
    end else begin
      send_stream(0, stream.size(), hold, cyc);
    end
    @(negedge clk);
    check({tag, "_nwr"}, 64'(wr_addr.size()), 64'(n));
    foreach (wr_addr[i]) begin
      if (i < n) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'(i));
        check($sformatf("%s_data%0d", tag, i), 64'(wr_data[i]), 64'(exp_words[i]));
      end
    end
    check({tag, "_done"}, 64'(done), 64'(good));
    check({tag, "_err"}, 64'(err), 64'(!good));
    check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(good));
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    if (hold) check({tag, "_cycles"}, 64'(cyc), 64'(3 + 5 * n));
    repeat (3) @(negedge clk);
    check({tag, "_sticky"}, 64'({done, err}), 64'({good, !good}));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit good;
    int cyc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wenb", 64'(mem_wenb), 64'd0);
    check("rst_webb", 64'(mem_webb), 64'd0);
    check("rst_addrb", 64'(mem_addrb), 64'd0);
    check("rst_datab", 64'(mem_datab), 64'd0);
    check("rst_status", 64'({core_rst_n, done, err}), 64'd0);
    rst = 1'b1;

    exp_words = '{32'h01402603, 32'h00167613};
    run_load("n2_good", -1, 1'b0, 0);

    exp_words = '{32'hDEADBEEF};
    run_load("n1_badchk", 0, 1'b0, 0);

    exp_words.delete();
    run_load("n0", 0, 1'b0, 0);

    // Oversized length aborts right after LEN_HI.
    exp_words.delete();
    build_stream(32'h4001, -1, good);
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_stream(0, 2, 1'b0, cyc);
    @(negedge clk);
    check("big_err", 64'(err), 64'd1);
    check("big_done", 64'(done), 64'd0);
    check("big_in_ready", 64'(in_ready), 64'd0);
    check("big_core_rst_n", 64'(core_rst_n), 64'd0);
    check("big_nwr", 64'(wr_addr.size()), 64'd0);

    exp_words.delete();
    for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
    run_load("hold_n3", -1, 1'b1, 0);

    exp_words.delete();
    for (int i = 0; i < 2; i++) exp_words.push_back($urandom);
    run_load("start_ignored", -1, 1'b0, 5);

    for (int t = 0; t < 20; t++) begin
      exp_words.delete();
      for (int i = 0; i < int'($urandom_range(6)); i++) exp_words.push_back($urandom);
      run_load($sformatf("rnd%0d", t), ($urandom_range(3) == 0) ? int'($urandom_range(255)) : -1,
               1'($urandom_range(1)), 0);
    end

    // Reset after the second data byte, then a fresh single-word load.
    exp_words.delete();
    for (int i = 0; i < 2; i++) exp_words.push_back($urandom);
    build_stream(2, -1, good);
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_stream(0, 4, 1'b0, cyc);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_webb", 64'({mem_wenb, mem_webb}), 64'd0);
    check("mid_rst_addrb", 64'(mem_addrb), 64'd0);
    check("mid_rst_datab", 64'(mem_datab), 64'd0);
    check("mid_rst_status", 64'({core_rst_n, done, err}), 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_nwr", 64'(wr_addr.size()), 64'd0);
    exp_words.delete();
    exp_words.push_back($urandom);
    run_load("after_rst", -1, 1'b0, 0);

    check("webb_pattern", 64'(webb_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
